memory_responder: RTL and testbench
===================================

# memory_responder

Responder end of the processor memory bus: accepts address-phase requests on `addr`/`write`/`size`/`prot`/`trans` from the processor, serves them from an internal word-organised RAM, and returns `rdata`, `abort` and a `ready` stall signal in the following data phase. Adds programmable wait states for non-sequential transfers and access checking (range, alignment, privilege). Sits alongside the processor in place of the behavioural test memory, for benches and synthesis alike.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; power of two.
- `N_WAIT`, 2: extra data-phase cycles for non-sequential transfers; 0–15.
- `PRIV_TOP`, 32'h0000_0100: byte addresses below this are privileged-only for writes.

- `clk`  in  1  clock; all logic on rising edge.
- `n_reset`  in  1  reset is synchronous and active-low.
- `addr`  in  32  byte address, address phase.
- `write`  in  1  1 = write, address phase.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `prot`  in  2  bit0: 0 opcode fetch / 1 data; bit1: 0 user / 1 privileged.
- `trans`  in  2  00 idle, 01 coprocessor (treated idle), 10 non-sequential, 11 sequential.
- `wdata`  in  32  write data, data phase.
- `rdata`  out  32  read data, valid when `ready`=1 in data phase.
- `abort`  out  1  transfer faulted; valid when `ready`=1.
- `ready`  out  1  1 = data phase completes this cycle / new address phase accepted.

## Operation
- Pipelined two-phase bus: address phase accepted on a rising edge with `ready`=1 and `trans[1]`=1; data phase follows.
- States: IDLE (no transfer pending), WAIT (counting wait states, `ready`=0), DATA (`ready`=1, response driven).
- IDLE → DATA if accepted transfer is sequential or `N_WAIT`=0; IDLE → WAIT if non-sequential and `N_WAIT`>0.
- WAIT → DATA after `N_WAIT` cycles of `ready`=0 (down-counter loaded with `N_WAIT`-1).
- DATA → next state chosen by the address phase accepted at the same edge (back-to-back); → IDLE if `trans` idle.
- Fault checks at acceptance, result registered: word index ≥ `DEPTH_WORDS`; misaligned (halfword with `addr[0]`, word with `addr[1:0]`≠0); `size`=11; write with `prot[1]`=0 and `addr` < `PRIV_TOP`.
- Faulted transfer: still takes its wait states; `abort`=1 with `ready`=1; `rdata`=0; RAM unchanged.
- Write: `wdata` captured on the edge ending the data phase; little-endian lane enables: byte → lane `addr[1:0]` from `wdata` of that lane, halfword → lanes `{addr[1],0}`/`{addr[1],1}`, word → all four.
- Read: full word fetched; byte replicated into all four lanes, halfword into both halves, word as stored.
- `abort` and `rdata` are 0 whenever `ready`=1 outside a DATA state, and during WAIT.

## Timing
- Reset (`n_reset`=0 at an edge): state IDLE, `ready`=1, `abort`=0, `rdata`=0, counter 0; RAM contents not reset.
- Reset during WAIT/DATA: transfer dropped; pending write not performed.
- Latency, address edge to response: sequential or `N_WAIT`=0 → 1 cycle; non-sequential → 1+`N_WAIT` cycles.
- Address-phase signals ignored while `ready`=0; processor holds them.
- Read-after-write to same address back-to-back returns new data (write commits at the edge the read's address phase is accepted; read array access occurs after).
- Sequential transfer after idle treated as sequential (no wait states); no burst-boundary check.

## Structure
- Package `bus_pkg`: `trans_t` (IDLE, COPRO, NSEQ, SEQ), `size_t` (BYTE, HALF, WORD, RSVD), prot bit indices, responder state enum.
- Sub-module `byte_lane_ram`: `DEPTH_WORDS`×32 synchronous-write array with 4 byte write enables, word-index read port; no reset.
- Top holds address/control registers, wait counter, fault logic, lane steering.

## Test plan
- Reset then idle: `n_reset`=0 two cycles, `trans`=00 → `ready`=1, `abort`=0, `rdata`=0 every cycle.
- NSEQ word write 32'hDEADBEEF at 0x200, `prot`=11, then NSEQ word read 0x200 with `N_WAIT`=2 → `ready` low 2 cycles each, read returns 32'hDEADBEEF, `abort`=0.
- Byte write 8'h5A at 0x203 over that word, SEQ byte read 0x203 → no wait, `rdata`=32'h5A5A5A5A; word read 0x200 → 32'h5AADBEEF.
- Faults: halfword read 0x201, `size`=11, read at `DEPTH_WORDS`*4, user write 0x0010 → each `abort`=1 with `ready`=1, `rdata`=0; subsequent read of 0x0010 unchanged.
- Back-to-back SEQ writes 0x300, 0x304 then SEQ read 0x300, 0x304 → no stalls, data returned in order.
- `n_reset` low during WAIT of write to 0x400 → `ready`=1 next cycle, later read of 0x400 shows prior contents.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus encodings and responder state for memory_responder
package bus_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'b00,
    TR_COPRO = 2'b01,
    TR_NSEQ  = 2'b10,
    TR_SEQ   = 2'b11
  } trans_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  localparam int PROT_DATA = 0;
  localparam int PROT_PRIV = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DATA = 2'b10
  } resp_state_t;

  // Little-endian byte-lane enables for a transfer of size sz at byte offset lo
  function automatic logic [3:0] lane_mask(size_t sz, logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - processor memory bus signals with master/slave views
interface memory_responder_if;
  logic [31:0] addr;
  logic        write;
  logic [1:0]  size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        abort;
  logic        ready;

  modport master (
    output addr, write, size, prot, trans, wdata,
    input  rdata, abort, ready
  );

  modport slave (
    input  addr, write, size, prot, trans, wdata,
    output rdata, abort, ready
  );
endinterface

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - word array with per-byte write enables and word read port
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read is combinational so a write committed at an edge is visible right after it
  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - pipelined bus responder with wait states and access checks
module memory_responder
  import bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          N_WAIT      = 2,
  parameter logic [31:0] PRIV_TOP    = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               n_reset,
  memory_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  resp_state_t   state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] a_idx;
  logic [1:0]    a_lo;
  logic          a_write;
  size_t         a_size;
  logic          a_fault;

  logic          accept;
  logic          fault_now;
  logic [3:0]    we;
  logic [31:0]   word;
  logic [31:0]   steered;
  logic          unused_prot;

  assign unused_prot = bus.prot[PROT_DATA];

  assign bus.ready = (state != ST_WAIT);
  assign accept    = bus.ready & bus.trans[1];

  always_comb begin
    fault_now = 1'b0;
    if ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS)) fault_now = 1'b1;
    case (size_t'(bus.size))
      SZ_HALF: if (bus.addr[0])           fault_now = 1'b1;
      SZ_WORD: if (bus.addr[1:0] != 2'b0) fault_now = 1'b1;
      SZ_RSVD:                            fault_now = 1'b1;
      default: ;
    endcase
    if (bus.write && !bus.prot[PROT_PRIV] && (bus.addr < PRIV_TOP)) fault_now = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          if ((trans_t'(bus.trans) == TR_SEQ) || (N_WAIT == 0)) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(N_WAIT - 1);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_DATA;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      a_idx   <= '0;
      a_lo    <= 2'b00;
      a_write <= 1'b0;
      a_size  <= SZ_WORD;
      a_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        a_idx   <= bus.addr[AW+1:2];
        a_lo    <= bus.addr[1:0];
        a_write <= bus.write;
        a_size  <= size_t'(bus.size);
        a_fault <= fault_now;
      end
    end
  end

  // Write lands on the edge that closes the data phase; a reset at that edge cancels it
  assign we = (state == ST_DATA && a_write && !a_fault && n_reset) ? lane_mask(a_size, a_lo) : 4'b0000;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(a_idx),
    .wdata(bus.wdata),
    .raddr(a_idx),
    .rdata(word)
  );

  always_comb begin
    steered = word;
    case (a_size)
      SZ_BYTE: steered = {4{word[8*a_lo +: 8]}};
      SZ_HALF: steered = a_lo[1] ? {2{word[31:16]}} : {2{word[15:0]}};
      default: steered = word;
    endcase
  end

  assign bus.rdata = (state == ST_DATA && !a_fault && !a_write) ? steered : 32'h0;
  assign bus.abort = (state == ST_DATA) && a_fault;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed vector bench for memory_responder
module tb_memory_responder;

  logic clk = 1'b0;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;

  memory_responder_if bus();

  memory_responder #(
    .DEPTH_WORDS(1024),
    .N_WAIT     (2),
    .PRIV_TOP   (32'h0000_0100)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tr;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  sz;
    logic [1:0]  pr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ab;
    int          exp_w;
  } vec_t;

  typedef struct {
    logic [1:0]  tr;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } step_t;

  vec_t  vecs[16];
  step_t steps[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                            input logic [1:0] sz, input logic [1:0] pr);
    bus.trans = tr;
    bus.addr  = a;
    bus.write = wr;
    bus.size  = sz;
    bus.prot  = pr;
  endtask

  task automatic xfer(input string name, input vec_t v);
    int waits;
    check({name, " ready_at_addr"}, 32'(bus.ready), 32'd1);
    drive_addr(v.tr, v.addr, v.wr, v.sz, v.pr);
    tick();
    bus.trans = 2'b00;
    bus.wdata = v.wd;
    waits = 0;
    while (!bus.ready && waits < 20) begin
      waits++;
      tick();
    end
    check({name, " waits"}, 32'(waits), 32'(v.exp_w));
    check({name, " abort"}, 32'(bus.abort), 32'(v.exp_ab));
    if (!v.wr || v.exp_ab) check({name, " rdata"}, bus.rdata, v.exp_rd);
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'b10, 32'h200,  1'b1, 2'b10, 2'b11, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{2'b10, 32'h200,  1'b0, 2'b10, 2'b11, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{2'b10, 32'h203,  1'b1, 2'b00, 2'b11, 32'h5A000000, 32'h0,        1'b0, 2};
    vecs[3]  = '{2'b11, 32'h203,  1'b0, 2'b00, 2'b11, 32'h0,        32'h5A5A5A5A, 1'b0, 0};
    vecs[4]  = '{2'b11, 32'h200,  1'b0, 2'b10, 2'b11, 32'h0,        32'h5AADBEEF, 1'b0, 0};
    vecs[5]  = '{2'b11, 32'h200,  1'b0, 2'b00, 2'b11, 32'h0,        32'hEFEFEFEF, 1'b0, 0};
    vecs[6]  = '{2'b11, 32'h202,  1'b0, 2'b01, 2'b11, 32'h0,        32'h5AAD5AAD, 1'b0, 0};
    vecs[7]  = '{2'b11, 32'h202,  1'b1, 2'b01, 2'b11, 32'h12340000, 32'h0,        1'b0, 0};
    vecs[8]  = '{2'b11, 32'h200,  1'b0, 2'b10, 2'b11, 32'h0,        32'h1234BEEF, 1'b0, 0};
    vecs[9]  = '{2'b11, 32'h201,  1'b0, 2'b01, 2'b11, 32'h0,        32'h0,        1'b1, 0};
    vecs[10] = '{2'b11, 32'h200,  1'b0, 2'b11, 2'b11, 32'h0,        32'h0,        1'b1, 0};
    vecs[11] = '{2'b11, 32'h1000, 1'b0, 2'b10, 2'b11, 32'h0,        32'h0,        1'b1, 0};
    vecs[12] = '{2'b11, 32'h10,   1'b1, 2'b10, 2'b11, 32'hCAFEF00D, 32'h0,        1'b0, 0};
    vecs[13] = '{2'b10, 32'h10,   1'b1, 2'b10, 2'b01, 32'h12345678, 32'h0,        1'b1, 2};
    vecs[14] = '{2'b11, 32'h10,   1'b0, 2'b10, 2'b01, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    vecs[15] = '{2'b10, 32'h400,  1'b1, 2'b10, 2'b11, 32'h0BADF00D, 32'h0,        1'b0, 2};

    steps[0] = '{2'b11, 32'h300, 1'b1, 32'hA1A1A1A1, 32'h0};
    steps[1] = '{2'b11, 32'h304, 1'b1, 32'hB2B2B2B2, 32'h0};
    steps[2] = '{2'b11, 32'h300, 1'b0, 32'h0,        32'hA1A1A1A1};
    steps[3] = '{2'b11, 32'h304, 1'b0, 32'h0,        32'hB2B2B2B2};
    steps[4] = '{2'b11, 32'h308, 1'b1, 32'hC3C3C3C3, 32'h0};
    steps[5] = '{2'b11, 32'h308, 1'b0, 32'h0,        32'hC3C3C3C3};

    n_reset = 1'b0;
    drive_addr(2'b00, 32'h0, 1'b0, 2'b10, 2'b11);
    bus.wdata = 32'h0;

    for (int c = 0; c < 3; c++) begin
      if (c == 2) n_reset = 1'b1;
      tick();
      check($sformatf("reset%0d ready", c), 32'(bus.ready), 32'd1);
      check($sformatf("reset%0d abort", c), 32'(bus.abort), 32'd0);
      check($sformatf("reset%0d rdata", c), bus.rdata, 32'h0);
    end

    for (int i = 0; i < 16; i++) xfer($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back sequential stream, including read-after-write to 0x308
    drive_addr(steps[0].tr, steps[0].addr, steps[0].wr, 2'b10, 2'b11);
    tick();
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("b2b%0d ready", i - 1), 32'(bus.ready), 32'd1);
      if (!steps[i-1].wr) check($sformatf("b2b%0d rdata", i - 1), bus.rdata, steps[i-1].exp_rd);
      bus.wdata = steps[i-1].wd;
      if (i < 6) drive_addr(steps[i].tr, steps[i].addr, steps[i].wr, 2'b10, 2'b11);
      else       bus.trans = 2'b00;
      tick();
    end

    // Reset in the middle of a write's wait states drops the write
    drive_addr(2'b10, 32'h400, 1'b1, 2'b10, 2'b11);
    tick();
    check("rst_wait ready_low", 32'(bus.ready), 32'd0);
    bus.trans = 2'b00;
    bus.wdata = 32'hFFFFFFFF;
    n_reset   = 1'b0;
    tick();
    n_reset = 1'b1;
    check("rst_wait ready", 32'(bus.ready), 32'd1);
    check("rst_wait abort", 32'(bus.abort), 32'd0);
    check("rst_wait rdata", bus.rdata, 32'h0);

    // Reset during a write's data phase also drops it
    drive_addr(2'b11, 32'h400, 1'b1, 2'b10, 2'b11);
    tick();
    check("rst_data ready", 32'(bus.ready), 32'd1);
    bus.trans = 2'b00;
    bus.wdata = 32'h77777777;
    n_reset   = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();

    xfer("readback400", '{2'b10, 32'h400, 1'b0, 2'b10, 2'b11, 32'h0, 32'h0BADF00D, 1'b0, 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
